// File: rtl/local_node.sv
// local_node: traffic endpoint on a router's Local port.
//
// Generator side injects PACKETS single-flit packets whose value is a pseudo-random destination
// node ID (never this node's own ID). Sink side acknowledges every flit the router delivers,
// after ACK_DELAY wait cycles, and counts flits whose value differs from ID as errors.
//
// Ports:
//   clk_i          clock, all state changes on the rising edge
//   reset_i        synchronous active-high reset
//   enable_i       lets the generator count gap cycles and launch flits
//   tx_req_o       request toward router rx_req[4]
//   tx_ack_i       acknowledge from router rx_ack[4]
//   tx_data_o      flit toward router (destination node ID)
//   rx_req_i       request from router tx_req[4]
//   rx_ack_o       acknowledge toward router tx_ack[4]
//   rx_data_i      flit from router
//   sent_count_o   flits injected (saturating)
//   recv_count_o   flits received (saturating)
//   err_count_o    received flits not addressed to ID (saturating)
//   done_o         all PACKETS flits injected
//
// SIZE must not exceed 16: the candidate destination is taken from the low SIZE LFSR bits.
module local_node #(
   parameter int          ID         = -1,
   parameter int unsigned SIZE       = 8,
   parameter int unsigned NODE_COUNT = 16,
   parameter int unsigned PACKETS    = 16,
   parameter int unsigned GAP        = 4,
   parameter int unsigned ACK_DELAY  = 0,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            enable_i,
   output logic            tx_req_o,
   input  logic            tx_ack_i,
   output logic [SIZE-1:0] tx_data_o,
   input  logic            rx_req_i,
   output logic            rx_ack_o,
   input  logic [SIZE-1:0] rx_data_i,
   output logic [15:0]     sent_count_o,
   output logic [15:0]     recv_count_o,
   output logic [15:0]     err_count_o,
   output logic            done_o
);

   localparam logic [SIZE:0]   NcW     = (SIZE+1)'(NODE_COUNT);
   localparam logic [SIZE:0]   IdW     = (SIZE+1)'(ID);
   localparam logic [SIZE-1:0] IdS     = SIZE'(ID);
   localparam logic [SIZE-1:0] NextS   = SIZE'((ID + 1) % int'(NODE_COUNT));
   localparam logic [15:0]     GapW    = 16'(GAP);
   localparam logic [15:0]     PktW    = 16'(PACKETS);
   localparam logic [15:0]     AckLast = (ACK_DELAY == 0) ? 16'd0 : 16'(ACK_DELAY - 1);

   typedef enum logic [1:0] {GenIdle, GenGap, GenSend, GenDone} gen_state_e;
   typedef enum logic [1:0] {SnkIdle, SnkWait, SnkAck} snk_state_e;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   gen_state_e      gen_state_q, gen_state_d;
   snk_state_e      snk_state_q, snk_state_d;
   logic [15:0]     lfsr_q, lfsr_d, lfsr_next;
   logic [15:0]     gap_cnt_q, gap_cnt_d;
   logic [15:0]     dly_cnt_q, dly_cnt_d;
   logic [15:0]     sent_q, sent_d, sent_inc;
   logic [15:0]     recv_q, recv_d;
   logic [15:0]     err_q, err_d;
   logic            tx_req_q, tx_req_d;
   logic [SIZE-1:0] tx_data_q, tx_data_d;
   logic            rx_ack_q, rx_ack_d;
   logic            done_q, done_d;
   logic            lfsr_fb;
   logic [SIZE:0]   cand;
   logic [SIZE-1:0] dest;

   // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
   assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
   assign lfsr_next = {lfsr_fb, lfsr_q[15:1]};

   // Extra top bit lets NODE_COUNT reach 2^SIZE
   assign cand     = {1'b0, lfsr_q[SIZE-1:0]} % NcW;
   assign dest     = (cand == IdW) ? NextS : cand[SIZE-1:0];
   assign sent_inc = sat_inc(sent_q);

   // Generator
   always_comb begin
      gen_state_d = gen_state_q;
      gap_cnt_d   = gap_cnt_q;
      tx_data_d   = tx_data_q;
      sent_d      = sent_q;
      lfsr_d      = lfsr_q;
      unique case (gen_state_q)
         GenIdle: begin
            if (PACKETS == 0) begin
               gen_state_d = GenDone;
            end else if (enable_i) begin
               gen_state_d = GenGap;
               gap_cnt_d   = '0;
            end
         end
         GenGap: begin
            // enable_i low freezes the whole gap phase, launch included
            if (enable_i) begin
               if (gap_cnt_q == GapW) begin
                  gen_state_d = GenSend;
                  tx_data_d   = dest;
               end else begin
                  gap_cnt_d = gap_cnt_q + 16'd1;
               end
            end
         end
         GenSend: begin
            if (tx_ack_i) begin
               sent_d = sent_inc;
               lfsr_d = lfsr_next;
               if (sent_inc == PktW) begin
                  gen_state_d = GenDone;
               end else begin
                  gen_state_d = GenGap;
                  gap_cnt_d   = '0;
               end
            end
         end
         GenDone: gen_state_d = GenDone;
         default: gen_state_d = GenIdle;
      endcase
      tx_req_d = (gen_state_d == GenSend);
      done_d   = (gen_state_d == GenDone);
   end

   // Sink
   always_comb begin
      snk_state_d = snk_state_q;
      dly_cnt_d   = dly_cnt_q;
      rx_ack_d    = 1'b0;
      recv_d      = recv_q;
      err_d       = err_q;
      unique case (snk_state_q)
         SnkIdle: begin
            if (rx_req_i) begin
               if (ACK_DELAY == 0) begin
                  snk_state_d = SnkAck;
                  rx_ack_d    = 1'b1;
               end else begin
                  snk_state_d = SnkWait;
                  dly_cnt_d   = '0;
               end
            end
         end
         SnkWait: begin
            if (dly_cnt_q == AckLast) begin
               snk_state_d = SnkAck;
               rx_ack_d    = 1'b1;
            end else begin
               dly_cnt_d = dly_cnt_q + 16'd1;
            end
         end
         SnkAck: begin
            // rx_ack_o is high this cycle and the router holds rx_req, so this edge transfers
            snk_state_d = SnkIdle;
            recv_d      = sat_inc(recv_q);
            if (rx_data_i != IdS) begin
               err_d = sat_inc(err_q);
            end
         end
         default: snk_state_d = SnkIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         gen_state_q <= GenIdle;
         snk_state_q <= SnkIdle;
         lfsr_q      <= SEED;
         gap_cnt_q   <= '0;
         dly_cnt_q   <= '0;
         sent_q      <= '0;
         recv_q      <= '0;
         err_q       <= '0;
         tx_req_q    <= 1'b0;
         tx_data_q   <= '0;
         rx_ack_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         gen_state_q <= gen_state_d;
         snk_state_q <= snk_state_d;
         lfsr_q      <= lfsr_d;
         gap_cnt_q   <= gap_cnt_d;
         dly_cnt_q   <= dly_cnt_d;
         sent_q      <= sent_d;
         recv_q      <= recv_d;
         err_q       <= err_d;
         tx_req_q    <= tx_req_d;
         tx_data_q   <= tx_data_d;
         rx_ack_q    <= rx_ack_d;
         done_q      <= done_d;
      end
   end

   assign tx_req_o     = tx_req_q;
   assign tx_data_o    = tx_data_q;
   assign rx_ack_o     = rx_ack_q;
   assign sent_count_o = sent_q;
   assign recv_count_o = recv_q;
   assign err_count_o  = err_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_local_node.sv
// Self-checking bench for local_node. Three instances:
//   A: ID=3, GAP=4, ACK_DELAY=2, 12 packets; enable pause and randomized traffic against a
//      transaction-level model (destination list, gap budget in enabled edges, sink ack age).
//   B: ID=5, GAP=0, seed whose first candidate is 5 (expects 6); stall, reset in send.
//   C: ID=15, seed whose first candidate is 15 (expects 0).
module tb_local_node;

   localparam int          Nc    = 16;
   localparam int          AId   = 3;
   localparam int          APkts = 12;
   localparam int          AGap  = 4;
   localparam int          ADly  = 2;
   localparam logic [15:0] ASeed = 16'hACE1;
   localparam int          BId   = 5;
   localparam int          BPkts = 3;
   localparam logic [15:0] BSeed = 16'h0005;
   localparam int          CId   = 15;
   localparam logic [15:0] CSeed = 16'h000F;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       a_en, a_tx_ack, a_rx_req, a_tx_req, a_rx_ack, a_done;
   logic [7:0] a_rx_data, a_tx_data;
   logic [15:0] a_sent, a_recv, a_err;
   logic       b_en, b_tx_ack, b_rx_req, b_tx_req, b_rx_ack, b_done;
   logic [7:0] b_rx_data, b_tx_data;
   logic [15:0] b_sent, b_recv, b_err;
   logic       c_en, c_tx_ack, c_rx_req, c_tx_req, c_rx_ack, c_done;
   logic [7:0] c_rx_data, c_tx_data;
   logic [15:0] c_sent, c_recv, c_err;

   local_node #(.ID(AId), .SIZE(8), .NODE_COUNT(Nc), .PACKETS(APkts), .GAP(AGap),
                .ACK_DELAY(ADly), .SEED(ASeed)) u_a (
      .clk_i(clk), .reset_i(rst), .enable_i(a_en),
      .tx_req_o(a_tx_req), .tx_ack_i(a_tx_ack), .tx_data_o(a_tx_data),
      .rx_req_i(a_rx_req), .rx_ack_o(a_rx_ack), .rx_data_i(a_rx_data),
      .sent_count_o(a_sent), .recv_count_o(a_recv), .err_count_o(a_err), .done_o(a_done)
   );

   local_node #(.ID(BId), .SIZE(8), .NODE_COUNT(Nc), .PACKETS(BPkts), .GAP(0),
                .ACK_DELAY(0), .SEED(BSeed)) u_b (
      .clk_i(clk), .reset_i(rst), .enable_i(b_en),
      .tx_req_o(b_tx_req), .tx_ack_i(b_tx_ack), .tx_data_o(b_tx_data),
      .rx_req_i(b_rx_req), .rx_ack_o(b_rx_ack), .rx_data_i(b_rx_data),
      .sent_count_o(b_sent), .recv_count_o(b_recv), .err_count_o(b_err), .done_o(b_done)
   );

   local_node #(.ID(CId), .SIZE(8), .NODE_COUNT(Nc), .PACKETS(1), .GAP(0),
                .ACK_DELAY(1), .SEED(CSeed)) u_c (
      .clk_i(clk), .reset_i(rst), .enable_i(c_en),
      .tx_req_o(c_tx_req), .tx_ack_i(c_tx_ack), .tx_data_o(c_tx_data),
      .rx_req_i(c_rx_req), .rx_ack_o(c_rx_ack), .rx_data_i(c_rx_data),
      .sent_count_o(c_sent), .recv_count_o(c_recv), .err_count_o(c_err), .done_o(c_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // LFSR state after n steps: each step shifts right, new MSB = XOR of the tapped bits
   function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
      int          taps [4] = '{16, 14, 13, 11};
      logic [15:0] l = s;
      logic        fb;
      for (int i = 0; i < n; i++) begin
         fb = 1'b0;
         foreach (taps[j]) fb ^= l[16 - taps[j]];
         l = {fb, l[15:1]};
      end
      return l;
   endfunction

   // Destination of the k-th injected flit
   function automatic int dest_of(input logic [15:0] seed, input int k, input int id,
                                  input int nc);
      logic [15:0] l = lfsr_adv(seed, k);
      int          cand = int'(l[7:0]) % nc;
      return (cand == id) ? (id + 1) % nc : cand;
   endfunction

   initial begin
      int   got_q [$];
      int   flits [$];
      int   exp_sent, en_left, age, exp_recv, exp_err;
      logic exp_req, exp_done, exp_ack, rx_x;

      {a_en, a_tx_ack, a_rx_req, b_en, b_tx_ack, b_rx_req, c_en, c_tx_ack, c_rx_req} = '0;
      a_rx_data = '0;
      b_rx_data = '0;
      c_rx_data = '0;

      // Reset values
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_a_tx_req", a_tx_req, 0);
      check_eq("rst_a_tx_data", a_tx_data, 0);
      check_eq("rst_a_rx_ack", a_rx_ack, 0);
      check_eq("rst_a_sent", a_sent, 0);
      check_eq("rst_a_recv", a_recv, 0);
      check_eq("rst_a_err", a_err, 0);
      check_eq("rst_a_done", a_done, 0);
      check_eq("rst_b_tx_req", b_tx_req, 0);

      // B: GAP=0 so tx_req rises one edge after the first enabled edge; hold tx_ack low
      b_en = 1'b1;
      c_en = 1'b1;
      tick();
      tick();
      check_eq("b_first_req", b_tx_req, 1);
      check_eq("b_self_avoid", b_tx_data, 6);
      check_eq("b_first_dest", b_tx_data, dest_of(BSeed, 0, BId, Nc));
      check_eq("c_first_req", c_tx_req, 1);
      check_eq("c_self_avoid", c_tx_data, 0);
      check_eq("c_first_dest", c_tx_data, dest_of(CSeed, 0, CId, Nc));
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("b_stall_req", b_tx_req, 1);
         check_eq("b_stall_data", b_tx_data, 6);
         check_eq("b_stall_sent", b_sent, 0);
      end
      b_tx_ack = 1'b1;
      tick();
      check_eq("b_xfer1_sent", b_sent, 1);
      check_eq("b_xfer1_req_drop", b_tx_req, 0);
      tick();
      check_eq("b_req2", b_tx_req, 1);
      check_eq("b_data2", b_tx_data, dest_of(BSeed, 1, BId, Nc));
      tick();
      check_eq("b_xfer2_sent", b_sent, 2);
      b_tx_ack = 1'b0;
      tick();
      check_eq("b_req3", b_tx_req, 1);
      check_eq("b_data3", b_tx_data, dest_of(BSeed, 2, BId, Nc));

      // Reset while B is holding a flit
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("b_midrst_req", b_tx_req, 0);
      check_eq("b_midrst_sent", b_sent, 0);
      check_eq("b_midrst_done", b_done, 0);
      check_eq("b_midrst_data", b_tx_data, 0);

      // Full run with tx_ack tied high: destinations restart from the seed
      b_tx_ack = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (b_tx_req && b_tx_ack) got_q.push_back(int'(b_tx_data));
         tick();
      end
      check_eq("b_run_count", got_q.size(), BPkts);
      foreach (got_q[i]) begin
         check_eq("b_run_dest", got_q[i], dest_of(BSeed, i, BId, Nc));
         check_eq("b_run_not_self", got_q[i] == BId, 0);
      end
      check_eq("b_run_sent", b_sent, BPkts);
      check_eq("b_run_done", b_done, 1);
      check_eq("b_run_req_idle", b_tx_req, 0);

      // A: enable pause. Two gap increments, 5 frozen edges; once enable is back, the
      // remaining two increments plus the launch edge put tx_req high 2 edges after the
      // first edge that sees enable again.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      a_en = 1'b1;
      tick();
      tick();
      tick();
      a_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("a_pause_req", a_tx_req, 0);
      end
      a_en = 1'b1;
      tick();
      check_eq("a_resume_r0", a_tx_req, 0);
      tick();
      check_eq("a_resume_r1", a_tx_req, 0);
      tick();
      check_eq("a_resume_r2", a_tx_req, 1);
      check_eq("a_resume_data", a_tx_data, dest_of(ASeed, 0, AId, Nc));

      // A: randomized traffic against the model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      a_en = 1'b0;
      a_tx_ack = 1'b0;
      a_rx_req = 1'b0;
      flits = '{3, 7, 3};
      exp_req = 1'b0;
      exp_done = 1'b0;
      exp_sent = 0;
      en_left = AGap + 2;   // IDLE->GAP edge plus GAP+1 enabled edges in the gap phase
      age = 0;              // edges rx_req has been held for the current flit
      exp_recv = 0;
      exp_err = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         exp_ack = (age == ADly + 1);
         check_eq("a_tx_req", a_tx_req, exp_req);
         if (exp_req) check_eq("a_tx_data", a_tx_data, dest_of(ASeed, exp_sent, AId, Nc));
         check_eq("a_sent", a_sent, exp_sent);
         check_eq("a_done", a_done, exp_done);
         check_eq("a_rx_ack", a_rx_ack, exp_ack);
         check_eq("a_recv", a_recv, exp_recv);
         check_eq("a_err", a_err, exp_err);

         a_en = ($urandom_range(0, 3) != 0);
         a_tx_ack = 1'($urandom_range(0, 1));
         if (!a_rx_req && $urandom_range(0, 1) == 1) begin
            a_rx_req = 1'b1;
            if (flits.size() > 0) a_rx_data = 8'(flits.pop_front());
            else if ($urandom_range(0, 1) == 1) a_rx_data = 8'(AId);
            else a_rx_data = 8'($urandom_range(0, Nc - 1));
         end
         rx_x = a_rx_req && a_rx_ack;

         if (exp_ack) begin
            exp_recv++;
            if (int'(a_rx_data) != AId) exp_err++;
            age = 0;
         end else if (a_rx_req) begin
            age++;
         end
         if (exp_req) begin
            if (a_tx_ack) begin
               exp_sent++;
               exp_req = 1'b0;
               if (exp_sent == APkts) exp_done = 1'b1;
               else en_left = AGap + 1;
            end
         end else if (!exp_done && a_en) begin
            en_left--;
            if (en_left == 0) exp_req = 1'b1;
         end

         tick();
         if (rx_x) a_rx_req = 1'b0;
      end
      check_eq("a_final_done", a_done, 1);
      check_eq("a_final_sent", a_sent, APkts);
      check_eq("a_final_recv", a_recv, exp_recv);
      check_eq("a_final_err", a_err, exp_err);
      check_eq("a_final_req", a_tx_req, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/local_node.md
# local_node

Traffic endpoint attached to a router's Local port (port index 4). It injects a fixed number of single-flit packets into the router's Local receive side and drains flits that the router delivers on its Local transmit side. Each flit's value is its destination node ID, which is the same word the router uses to look up its routing table. On ejection the block checks delivery correctness and keeps counters for bench and system-level checking.

## Interface

Parameters:
- ID, -1: node ID. Must be set in `[0, NODE_COUNT-1]` at instantiation.
- SIZE, 8: flit width in bits.
- NODE_COUNT, 16: number of nodes in the network. Range 2..2^SIZE.
- PACKETS, 16: number of flits to inject. 0 means the node only sinks.
- GAP, 4: idle cycles before each injection. 0 is allowed.
- ACK_DELAY, 0: cycles the sink waits before acknowledging a flit.
- SEED, 16'hACE1: 16-bit LFSR seed. Must be nonzero.

Ports:
- clk, input, 1: clock. All state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: allows injection to proceed.
- tx_req, output, 1: request toward router `rx_req[4]`.
- tx_ack, input, 1: acknowledge from router `rx_ack[4]`.
- tx_data, output, SIZE: flit toward router `rx_data[4*SIZE +: SIZE]`.
- rx_req, input, 1: request from router `tx_req[4]`.
- rx_ack, output, 1: acknowledge toward router `tx_ack[4]`.
- rx_data, input, SIZE: flit from router `tx_data[4*SIZE +: SIZE]`.
- sent_count, output, 16: flits injected.
- recv_count, output, 16: flits received.
- err_count, output, 16: received flits whose value is not ID.
- done, output, 1: injection of PACKETS flits is complete.

## Operation

Handshake (both directions):
- A transfer occurs on a rising edge where req=1 and ack=1.
- The sender holds req and data stable until that transfer edge.
- The sender never withdraws req without a transfer.

Destination generation:
- A 16-bit Fibonacci LFSR with taps 16,14,13,11 is loaded with SEED on reset.
- cand = `lfsr[SIZE-1:0] % NODE_COUNT`.
- dest = cand, except when cand == ID, in which case dest = `(ID+1) % NODE_COUNT`.
- The LFSR advances exactly once per completed injection transfer.

Generator FSM (states GEN_IDLE, GEN_GAP, GEN_SEND, GEN_DONE):
- GEN_IDLE
  - PACKETS == 0 → GEN_DONE.
  - enable=1 → GEN_GAP, with the gap counter cleared.
- GEN_GAP
  - The counter increments only while enable=1; enable=0 freezes it.
  - When the counter reaches GAP → GEN_SEND, registering `tx_data` = dest and `tx_req` = 1.
  - With GAP=0 the FSM passes through GEN_GAP in one cycle.
- GEN_SEND
  - `tx_req`=1. enable has no effect in this state.
  - On a transfer edge: sent_count increments and the LFSR steps.
  - If the new sent_count equals PACKETS → GEN_DONE; otherwise → GEN_GAP with the counter cleared.
  - `tx_req` drops in the cycle after the transfer.
- GEN_DONE
  - done=1 and `tx_req`=0. Terminal until reset.

Sink FSM (states SNK_IDLE, SNK_WAIT, SNK_ACK):
- SNK_IDLE
  - rx_req=1 → SNK_WAIT with the delay counter cleared.
  - When ACK_DELAY=0, go directly to SNK_ACK.
- SNK_WAIT
  - Count ACK_DELAY cycles, then → SNK_ACK.
- SNK_ACK
  - rx_ack=1 for exactly one cycle; that edge is the transfer edge, because rx_req is held.
  - recv_count increments.
  - err_count increments if rx_data ≠ ID.
  - → SNK_IDLE.
- Minimum spacing between accepted flits is therefore 2 cycles.

Counters:
- All three counters saturate at 16'hFFFF.

Generator and sink are independent and may transfer on the same edge.

## Timing

Reset values:
- tx_req=0, tx_data=0, rx_ack=0, all counters 0, done=0.
- Both FSMs go to their idle state; LFSR is loaded with SEED.

Reset in mid-operation:
- Reset overrides any in-flight handshake. Outputs return to reset values on the next edge.
- A flit held in GEN_SEND at reset is discarded and not counted.

Latencies:
- tx_req rises GAP+1 cycles after the first edge with enable=1 in GEN_IDLE.
- rx_ack rises ACK_DELAY+1 cycles after rx_req is first sampled high.

All outputs are registered. There are no combinational paths from input to output.

## Test plan

1. **Basic injection.** PACKETS=3, GAP=0, ID=0, tx_ack tied to 1, enable=1 after reset → three transfers with tx_data values matching the LFSR model (never 0), sent_count=3, done=1, and tx_req=0 thereafter.
2. **Stalled acknowledge.** tx_ack held 0 for 10 cycles during GEN_SEND → tx_req stays 1 and tx_data stays constant; the transfer completes on the first edge with tx_ack=1; sent_count increments once.
3. **Self-avoidance.** ID=5, NODE_COUNT=16, SEED forcing cand=5 → tx_data=6. Also ID=15 with cand=15 → tx_data=0.
4. **Sink timing and errors.** ACK_DELAY=2, ID=3; router delivers 3, 7, 3 with rx_req held → rx_ack pulses 3 cycles after each request is first seen; recv_count=3, err_count=1.
5. **Enable pause.** GAP=4, enable dropped for 5 cycles after 2 gap cycles → tx_req rises exactly 2 cycles after enable returns.
6. **Reset in GEN_SEND.** Assert reset for 1 cycle while tx_req=1 → next edge tx_req=0, sent_count=0, done=0, LFSR=SEED; a subsequent run repeats the first destination.
